param_shadow_bank: RTL
======================

# param_shadow_bank

Double-buffered parameter register bank that sits directly upstream of the parameter-consuming stage. It accepts single-entry writes into a shadow copy over a valid/ready port. On a commit request it transfers the whole shadow copy into the active copy in one atomic cycle. It then drives the active values as an indexed parameter array and announces each update with a valid/ack handshake, so the consumer never sees a partially written set.

## Interface
- `NUM`, 4, number of parameter entries (1..16; need not be a power of two)
- `DW`, 16, width of each entry in bits
- `AW`, 4, width of the write address; must satisfy 2^AW >= NUM
- `clk`  in  1  sole clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  bank can accept a write
- `wr_addr`  in  AW  shadow entry index
- `wr_data`  in  DW  shadow entry value
- `commit`  in  1  request shadow→active transfer; level-sampled
- `commit_busy`  out  1  high whenever the state is not IDLE
- `param_val`  out  NUM*DW  active entries; entry k occupies bits [k*DW +: DW]
- `upd_valid`  out  1  active set changed; held until acknowledged
- `upd_ack`  in  1  consumer acknowledges the update
- `err_addr`  out  1  sticky flag: a write to an address >= NUM was accepted

## Operation
- State machine:
  - IDLE
    - `wr_ready`=1.
    - Accepted write (`wr_valid & wr_ready`) updates `shadow[wr_addr]` at that edge.
    - `commit`=1 → APPLY.
  - APPLY (exactly one cycle)
    - `wr_ready`=0.
    - `active <= shadow` for all NUM entries at the exiting edge → NOTIFY.
  - NOTIFY
    - `wr_ready`=0, `upd_valid`=1.
    - Stays in NOTIFY until `upd_ack`=1; that edge → IDLE.
- Simultaneous write and commit in IDLE: the write is accepted and is included in the transfer, because shadow updates at the same edge that enters APPLY.
- `commit` in APPLY or NOTIFY is ignored and not queued. Software re-issues after `commit_busy` falls.
- `upd_ack` outside NOTIFY is ignored.
- Out-of-range write (`wr_addr >= NUM`):
  - The handshake completes normally.
  - Data is dropped; no shadow entry changes.
  - `err_addr` sets at that edge and stays set until reset.
- `param_val` changes only at the APPLY exit edge and is stable otherwise.
- Reset (async, any state including mid-APPLY/NOTIFY):
  - state → IDLE.
  - Shadow and active entries → 0, so `param_val` = 0.
  - `upd_valid`=0, `err_addr`=0, `commit_busy`=0, `wr_ready`=1.
  - A pending update is lost and no notification follows.

## Timing
- Write latency: the shadow entry is visible internally one edge after the handshake. It is not visible on `param_val` until commit.
- Commit sampled at edge N:
  - APPLY during cycle N..N+1.
  - `param_val` and `upd_valid` change at edge N+1.
- `upd_ack` sampled high at edge M: `upd_valid` falls and `wr_ready` rises at edge M. A new write or commit can be accepted at edge M+1.
- Minimum commit-to-commit spacing: 3 cycles (ack in the first NOTIFY cycle).
- `wr_ready`, `commit_busy` and `upd_valid` are decoded from registered state only, with no combinational path from inputs.

## Configuration
- Macro: `PARAM_SHADOW_BANK_READBACK_EN`.
- Defined: adds these ports:
  - `rd_addr` in AW
  - `rd_sel` in 1 (0 = shadow, 1 = active)
  - `rd_data` out DW
- Readback behaviour when defined:
  - `rd_data` is registered with 1-cycle latency and reset value 0.
  - Out-of-range `rd_addr` returns 0 and does not set `err_addr`.
  - Readback is allowed in every state.
- Undefined: these ports and the read register do not exist. All other behaviour is identical.

## Test plan
- Reset, then check outputs: expect `param_val`=0, `wr_ready`=1, `upd_valid`=0, `err_addr`=0. Write addr 2=0x1234 with no commit: `param_val` stays 0.
- Write 0x0001..0x0004 to addr 0..3, commit at edge N:
  - `param_val`=0x0004_0003_0002_0001 and `upd_valid`=1 at edge N+1.
  - Ack 2 cycles later: `upd_valid`=0 and `wr_ready`=1 at the ack edge.
- Write addr 1=0xBEEF with commit in the same cycle: after APPLY, entry 1 = 0xBEEF.
- Commit pulsed during NOTIFY: no second update. `upd_valid` falls once on ack and `param_val` is unchanged.
- Write to addr 5 with NUM=4: handshake completes, `err_addr`=1 next edge and sticky, all entries unchanged.
- Assert `rst` while in NOTIFY holding 0x00FF: `upd_valid`=0, `param_val`=0, `wr_ready`=1 immediately without a clock edge. With READBACK_EN, shadow readback of addr 0 also returns 0.

Source files
------------

// File: rtl/param_shadow_bank.sv
// Double-buffered parameter bank: writes land in a shadow copy, a commit copies it atomically to the active copy.
// Optional readback port enabled by PARAM_SHADOW_BANK_READBACK_EN.
module param_shadow_bank #(
    parameter int unsigned NUM = 4,
    parameter int unsigned DW  = 16,
    parameter int unsigned AW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              commit,
    output logic              commit_busy,
    output logic [NUM*DW-1:0] param_val,
    output logic              upd_valid,
    input  logic              upd_ack,
    output logic              err_addr
`ifdef PARAM_SHADOW_BANK_READBACK_EN
    ,
    input  logic [AW-1:0]     rd_addr,
    input  logic              rd_sel,
    output logic [DW-1:0]     rd_data
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] APPLY  = 2'd1;
    localparam logic [1:0] NOTIFY = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [DW-1:0] shadow [NUM];
    logic          wr_fire;
    logic          wr_in_range;

    assign wr_fire     = wr_valid & wr_ready;
    assign wr_in_range = (32'(wr_addr) < NUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (commit)  state_next = APPLY;
            APPLY:                state_next = NOTIFY;
            NOTIFY:  if (upd_ack) state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Status flags are registered copies of the next state, so they carry no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ready    <= 1'b1;
            commit_busy <= 1'b0;
            upd_valid   <= 1'b0;
        end else begin
            wr_ready    <= (state_next == IDLE);
            commit_busy <= (state_next != IDLE);
            upd_valid   <= (state_next == NOTIFY);
        end
    end

    // Shadow write; out-of-range addresses complete the handshake but only raise the sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM; k++) shadow[k] <= '0;
            err_addr <= 1'b0;
        end else if (wr_fire) begin
            for (int unsigned k = 0; k < NUM; k++)
                if (wr_addr == AW'(k)) shadow[k] <= wr_data;
            if (!wr_in_range) err_addr <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            param_val <= '0;
        end else if (state == APPLY) begin
            for (int unsigned k = 0; k < NUM; k++) param_val[k*DW +: DW] <= shadow[k];
        end
    end

`ifdef PARAM_SHADOW_BANK_READBACK_EN
    logic [DW-1:0] rd_next;

    always_comb begin
        rd_next = '0;
        for (int unsigned k = 0; k < NUM; k++)
            if (rd_addr == AW'(k)) rd_next = rd_sel ? param_val[k*DW +: DW] : shadow[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= rd_next;
    end
`endif

endmodule
